// File: rtl/shared_reg_arbiter_if.sv
// Purpose : bundles the requester-facing signals of shared_reg_arbiter.
// Latency : n/a (wires only).
// Backpressure: none; requesters hold req until they observe their gnt bit.
// Ports   : req/wdata/lock driven by requesters (master);
//           gnt/owner/q/q_valid driven by the arbiter (slave).
interface shared_reg_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   lock;
   logic [N-1:0]   gnt;
   logic [2:0]     owner;
   logic [W-1:0]   q;
   logic           q_valid;

   modport master (
      output req, wdata, lock,
      input  gnt, owner, q, q_valid
   );

   modport slave (
      input  req, wdata, lock,
      output gnt, owner, q, q_valid
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Purpose : round-robin arbiter owning one shared W-bit register written by N requesters.
// Latency : 1 cycle; req sampled at an edge updates gnt/q/owner/q_valid on that same edge.
// Backpressure: level req; a losing requester simply keeps req high until its gnt pulse.
// Ports   : clk, reset (async, active-high); bus (shared_reg_arbiter_if.slave):
//           req[N], wdata[N*W], lock[N] in; gnt[N] one-hot, owner[3], q[W], q_valid out.
// Config  : define SHARED_REG_ARB_LOCK_EN to enable burst locking (ARB/LOCKED FSM,
//           burst limited to MAX_BURST); otherwise lock is ignored.
module shared_reg_arbiter #(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                reset,
   shared_reg_arbiter_if.slave bus
);

   logic [N-1:0] gnt_q,     gnt_d;
   logic [W-1:0] q_q,       q_d;
   logic [2:0]   owner_q,   owner_d;
   logic [2:0]   ptr_q,     ptr_d;
   logic         q_valid_q, q_valid_d;

   // Round-robin search result
   logic         srch_vld;
   logic [2:0]   srch_idx;
   logic         hi_vld,  lo_vld;
   logic [2:0]   hi_idx,  lo_idx;

   // Final selection after lock handling
   logic         sel_vld;
   logic [2:0]   sel_idx;

   // Two passes replace a modulo search: first the requesters at or above ptr,
   // then wrap to the lowest requester overall.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!hi_vld && bus.req[i] && (3'(i) >= ptr_q)) begin
            hi_vld = 1'b1;
            hi_idx = 3'(i);
         end
         if (!lo_vld && bus.req[i]) begin
            lo_vld = 1'b1;
            lo_idx = 3'(i);
         end
      end
      srch_vld = hi_vld | lo_vld;
      srch_idx = hi_vld ? hi_idx : lo_idx;
   end

`ifdef SHARED_REG_ARB_LOCK_EN
   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] burst_q, burst_d;
   logic       own_req, own_lock, srch_lock;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      sel_vld   = srch_vld;
      sel_idx   = srch_idx;
      own_req   = 1'b0;
      own_lock  = 1'b0;
      srch_lock = 1'b0;

      for (int i = 0; i < N; i++) begin
         if (owner_q == 3'(i)) begin
            own_req  = bus.req[i];
            own_lock = bus.lock[i];
         end
         if (srch_idx == 3'(i)) begin
            srch_lock = bus.lock[i];
         end
      end

      case (state_q)
         LOCKED: begin
            if (own_req && own_lock) begin
               // Locked owner keeps the register regardless of other requests.
               sel_vld = 1'b1;
               sel_idx = owner_q;
               burst_d = burst_q + 4'd1;
               if (burst_d == 4'(MAX_BURST)) begin
                  // Forced release; ptr already moves past the owner below.
                  state_d = ARB;
                  burst_d = '0;
               end
            end else begin
               // Release edge falls back to normal arbitration, which may
               // itself start a new lock.
               state_d = ARB;
               burst_d = '0;
               if (srch_vld && srch_lock && (MAX_BURST > 1)) begin
                  state_d = LOCKED;
                  burst_d = 4'd1;
               end
            end
         end
         default: begin
            // A one-grant burst limit means the lock can never outlast its first grant.
            if (srch_vld && srch_lock && (MAX_BURST > 1)) begin
               state_d = LOCKED;
               burst_d = 4'd1;
            end
         end
      endcase
   end
`else
   logic unused_lock;

   assign unused_lock = ^bus.lock;
   assign sel_vld     = srch_vld;
   assign sel_idx     = srch_idx;
`endif

   always_comb begin
      gnt_d     = '0;
      q_d       = q_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      q_valid_d = q_valid_q;
      if (sel_vld) begin
         for (int i = 0; i < N; i++) begin
            if (sel_idx == 3'(i)) begin
               gnt_d[i] = 1'b1;
               q_d      = bus.wdata[i*W +: W];
            end
         end
         owner_d   = sel_idx;
         q_valid_d = 1'b1;
         ptr_d     = (sel_idx == 3'(N-1)) ? 3'd0 : sel_idx + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q     <= '0;
         q_q       <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         q_valid_q <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         q_q       <= q_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.q       = q_q;
   assign bus.owner   = owner_q;
   assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Purpose : directed self-checking bench for shared_reg_arbiter (N=4, W=8, MAX_BURST=4).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; the bench drives req/wdata/lock directly through the interface.
module tb_shared_reg_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

   shared_reg_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] q;
      logic [2:0] owner;
      logic       vld;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [3:0] lk_g [6];
   logic [7:0] lk_q [6];
   logic [2:0] lk_o [6];
   logic [3:0] rel_g;
   logic [7:0] rel_q;
   logic [2:0] rel_o;

   function automatic logic [31:0] pack4(input logic [7:0] b3, b2, b1, b0);
      return {b3, b2, b1, b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one cycle of stimulus, queue its expected result, and check it after the edge.
   task automatic step(input string tag, input logic [3:0] r, input logic [31:0] d,
                       input logic [3:0] lk, input logic [3:0] eg, input logic [7:0] eq,
                       input logic [2:0] eo, input logic ev);
      exp_t e;
      bus.req   = r;
      bus.wdata = d;
      bus.lock  = lk;
      e.gnt   = eg;
      e.q     = eq;
      e.owner = eo;
      e.vld   = ev;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".gnt"},   32'(bus.gnt),     32'(e.gnt));
      chk({tag, ".q"},     32'(bus.q),       32'(e.q));
      chk({tag, ".owner"}, 32'(bus.owner),   32'(e.owner));
      chk({tag, ".vld"},   32'(bus.q_valid), 32'(e.vld));
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, ".gnt"},   32'(bus.gnt),     32'h0);
      chk({tag, ".q"},     32'(bus.q),       32'h0);
      chk({tag, ".owner"}, 32'(bus.owner),   32'h0);
      chk({tag, ".vld"},   32'(bus.q_valid), 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SHARED_REG_ARB_LOCK_EN
      lk_g  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1};
      lk_q  = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hB1, 8'hA0};
      lk_o  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
      rel_g = 4'h2;
      rel_q = 8'hB1;
      rel_o = 3'd1;
`else
      lk_g  = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
      lk_q  = '{8'hA0, 8'hB1, 8'hA0, 8'hB1, 8'hA0, 8'hB1};
      lk_o  = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
      rel_g = 4'h1;
      rel_q = 8'hA0;
      rel_o = 3'd0;
`endif

      reset     = 1'b1;
      bus.req   = '0;
      bus.wdata = '0;
      bus.lock  = '0;
      @(posedge clk);
      #1;
      chk_cleared("reset");
      #3 reset = 1'b0;

      // Write A5, then reset asynchronously mid-cycle.
      step("first", 4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'hA5), 4'b0, 4'b0001, 8'hA5, 3'd0, 1'b1);
      #2 reset = 1'b1;
      #1 chk_cleared("async_rst");
      @(posedge clk);
      #1 chk_cleared("rst_held");
      #2 reset = 1'b0;

      // Stale ptr would be 1 and pick requester 1; a cleared ptr picks 0.
      step("post_rst", 4'b0011, pack4(8'h00, 8'h00, 8'h55, 8'h44), 4'b0, 4'b0001, 8'h44, 3'd0, 1'b1);

      step("single",     4'b0100, pack4(8'hEE, 8'h3C, 8'hDD, 8'hCC), 4'b0, 4'b0100, 8'h3C, 3'd2, 1'b1);
      step("single_off", 4'b0000, pack4(8'hEE, 8'h3C, 8'hDD, 8'hCC), 4'b0, 4'b0000, 8'h3C, 3'd2, 1'b1);

      // Grant to 3 so the all-request rotation starts at 0.
      step("to3", 4'b1000, pack4(8'h99, 8'h00, 8'h00, 8'h00), 4'b0, 4'b1000, 8'h99, 3'd3, 1'b1);

      for (int k = 0; k < 8; k++) begin
         step("all", 4'b1111, pack4(8'h13, 8'h12, 8'h11, 8'h10), 4'b0,
              4'(1 << (k % 4)), 8'(8'h10 + k % 4), 3'(k % 4), 1'b1);
      end

      step("wrap0",  4'b1001, pack4(8'h23, 8'h00, 8'h00, 8'h20), 4'b0, 4'b0001, 8'h20, 3'd0, 1'b1);
      step("wrap3",  4'b1001, pack4(8'h23, 8'h00, 8'h00, 8'h20), 4'b0, 4'b1000, 8'h23, 3'd3, 1'b1);
      step("wrap0b", 4'b1001, pack4(8'h23, 8'h00, 8'h00, 8'h20), 4'b0, 4'b0001, 8'h20, 3'd0, 1'b1);

      step("w77", 4'b0010, pack4(8'h00, 8'h00, 8'h77, 8'h00), 4'b0, 4'b0010, 8'h77, 3'd1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step("idle", 4'b0000, $urandom, 4'b0, 4'b0000, 8'h77, 3'd1, 1'b1);
      end

      for (int k = 0; k < 6; k++) begin
         step("lock", 4'b0011, pack4(8'h00, 8'h00, 8'hB1, 8'hA0), 4'b0001, lk_g[k], lk_q[k], lk_o[k], 1'b1);
      end
      step("unlock", 4'b0011, pack4(8'h00, 8'h00, 8'hB1, 8'hA0), 4'b0000, rel_g, rel_q, rel_o, 1'b1);

      step("pre_rst2", 4'b1000, pack4(8'h5A, 8'h00, 8'h00, 8'h00), 4'b0, 4'b1000, 8'h5A, 3'd3, 1'b1);
      #2 reset = 1'b1;
      #1 chk_cleared("async_rst2");

      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
